// File: rtl/prefix_arbiter.sv
// -----------------------------------------------------------------------------
// prefix_arbiter
//
// Purpose:
//   Shares one externally pipelined prefix adder (fixed latency LAT) between
//   two requesters. An accepted operation is registered into an issue stage
//   that drives the adder. A {valid, id} tag travels alongside the adder
//   pipeline, and the returning sum/carry is steered into the matching
//   response register.
//
// Configuration macro:
//   PREFIX_ARB_RR_EN  defined   -> round-robin arbitration. The requester that
//                                  was not granted at the last acceptance wins
//                                  a tie.
//                     undefined -> fixed priority. Requester 0 always wins.
//
// Parameters:
//   LAT  pipeline latency of the shared adder in cycles (>= 1)
//   W    operand / sum width
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_cin       operands and carry-in of requester N
//   add_a, add_b, add_cin          operands presented to the shared adder
//   add_y, add_cout                adder result for operands from LAT cycles ago
//   rspN_valid, rspN_sum, rspN_cout  one-cycle response pulse for requester N
//   idle                           no operation in issue, tag or response stage
// -----------------------------------------------------------------------------
module prefix_arbiter #(
    parameter int LAT = 4,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_y,
    input  logic         add_cout,
    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_sum,
    output logic         rsp0_cout,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_sum,
    output logic         rsp1_cout,
    output logic         idle
);

    logic           grant0_s;
    logic           grant1_s;
    logic           accept_s;

    logic           iss_vld_q, iss_vld_d;
    logic           iss_id_q,  iss_id_d;
    logic [W-1:0]   add_a_q,   add_a_d;
    logic [W-1:0]   add_b_q,   add_b_d;
    logic           add_cin_q, add_cin_d;

    logic [LAT-1:0] tag_vld_q, tag_vld_d;
    logic [LAT-1:0] tag_id_q,  tag_id_d;

    logic           rsp0_valid_q, rsp0_valid_d;
    logic [W-1:0]   rsp0_sum_q,   rsp0_sum_d;
    logic           rsp0_cout_q,  rsp0_cout_d;
    logic           rsp1_valid_q, rsp1_valid_d;
    logic [W-1:0]   rsp1_sum_q,   rsp1_sum_d;
    logic           rsp1_cout_q,  rsp1_cout_d;

    logic           idle_q, idle_d;

`ifdef PREFIX_ARB_RR_EN
    // Set when requester 1 should win the next tie.
    logic           prio1_q, prio1_d;
`endif

    // Grant selection. The ready signals must respond in the same cycle so a
    // lone requester sees no bubble. They are therefore combinational.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
`ifdef PREFIX_ARB_RR_EN
            grant0_s = ~prio1_q;
            grant1_s = prio1_q;
`else
            grant0_s = 1'b1;
            grant1_s = 1'b0;
`endif
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    assign accept_s = grant0_s | grant1_s;

    // Next-state logic for the issue stage, tag pipeline, response stage and idle flag.
    always_comb begin
        iss_vld_d = accept_s;
        iss_id_d  = iss_id_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        if (accept_s) begin
            iss_id_d = grant1_s;
            if (grant1_s) begin
                add_a_d   = req1_a;
                add_b_d   = req1_b;
                add_cin_d = req1_cin;
            end else begin
                add_a_d   = req0_a;
                add_b_d   = req0_b;
                add_cin_d = req0_cin;
            end
        end else begin
            // Adder operands hold so the adder input does not toggle needlessly.
            iss_id_d  = iss_id_q;
            add_a_d   = add_a_q;
            add_b_d   = add_b_q;
            add_cin_d = add_cin_q;
        end

        // The tag shifts every cycle, in lock-step with the adder's internal pipeline.
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = iss_vld_q;
        tag_id_d[0]  = iss_id_q;
        for (int k = 1; k < LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end

        // The tag leaving the pipeline qualifies add_y/add_cout in this same cycle.
        rsp0_valid_d = tag_vld_q[LAT-1] & ~tag_id_q[LAT-1];
        rsp1_valid_d = tag_vld_q[LAT-1] &  tag_id_q[LAT-1];
        if (rsp0_valid_d) begin
            rsp0_sum_d  = add_y;
            rsp0_cout_d = add_cout;
        end else begin
            rsp0_sum_d  = rsp0_sum_q;
            rsp0_cout_d = rsp0_cout_q;
        end
        if (rsp1_valid_d) begin
            rsp1_sum_d  = add_y;
            rsp1_cout_d = add_cout;
        end else begin
            rsp1_sum_d  = rsp1_sum_q;
            rsp1_cout_d = rsp1_cout_q;
        end

        // Idle is computed from next-state values, so the registered flag
        // describes the stage contents in the same cycle it is visible.
        idle_d = ~(iss_vld_d | (|tag_vld_d) | rsp0_valid_d | rsp1_valid_d);

`ifdef PREFIX_ARB_RR_EN
        if (accept_s) begin
            prio1_d = ~grant1_s;
        end else begin
            prio1_d = prio1_q;
        end
`endif
    end

    // State registers. Reset clears every tag, so stale adder output is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q    <= 1'b0;
            iss_id_q     <= 1'b0;
            add_a_q      <= {W{1'b0}};
            add_b_q      <= {W{1'b0}};
            add_cin_q    <= 1'b0;
            tag_vld_q    <= {LAT{1'b0}};
            tag_id_q     <= {LAT{1'b0}};
            rsp0_valid_q <= 1'b0;
            rsp0_sum_q   <= {W{1'b0}};
            rsp0_cout_q  <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_sum_q   <= {W{1'b0}};
            rsp1_cout_q  <= 1'b0;
            idle_q       <= 1'b1;
`ifdef PREFIX_ARB_RR_EN
            prio1_q      <= 1'b0;
`endif
        end else begin
            iss_vld_q    <= iss_vld_d;
            iss_id_q     <= iss_id_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_cin_q    <= add_cin_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_sum_q   <= rsp0_sum_d;
            rsp0_cout_q  <= rsp0_cout_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_sum_q   <= rsp1_sum_d;
            rsp1_cout_q  <= rsp1_cout_d;
            idle_q       <= idle_d;
`ifdef PREFIX_ARB_RR_EN
            prio1_q      <= prio1_d;
`endif
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_cin    = add_cin_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_sum   = rsp0_sum_q;
    assign rsp0_cout  = rsp0_cout_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_sum   = rsp1_sum_q;
    assign rsp1_cout  = rsp1_cout_q;
    assign idle       = idle_q;

endmodule
